mem_arbiter: RTL and testbench

Two-requester arbiter for the single synchronous port of the 64 KB system RAM. It shares the port between the Z80 bus (`cpu_*`) and a byte-stream program loader (`ld_*`) fed from the SD/ESP32 path. The CPU has priority, and a starvation counter guarantees the loader forward progress. CPU writes into the ROM window are suppressed.

---
 rtl/trs80_mem_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trs80_mem_pkg.sv
// Shared types and memory-map constants for the TRS-80 memory subsystem.
package trs80_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_ACC = 3'd1,
    CPU_CAP = 3'd2,
    CPU_ACK = 3'd3,
    LOAD    = 3'd4
  } mem_arb_state_t;

  localparam logic [15:0] ROM_TOP_DEFAULT = 16'h3000;
  localparam logic [15:0] VRAM_BASE       = 16'h3C00;
  localparam logic [7:0]  KBD_PAGE        = 8'h38;

  // Wide enough for the largest legal starvation limit (15).
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single synchronous RAM port between the Z80 bus and the program
// loader. CPU has priority; a starvation counter forces a loader slot after
// STARVE_LIMIT CPU grants with a loader byte waiting. CPU writes below
// ROM_TOP are dropped but still acknowledged.
module mem_arbiter
  import trs80_mem_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 16,
  parameter int unsigned        DATA_W       = 8,
  parameter int unsigned        STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0]  ROM_TOP      = ADDR_W'(ROM_TOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait_n,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  mem_arb_state_t      state_q, state_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                acc_rd_q, acc_rd_d;
  logic                ld_win_c;

  // Loader wins the idle slot when the CPU is quiet or has starved it.
  assign ld_win_c = ld_valid & (~cpu_req | (starve_q == STARVE_MAX));

  // Next-state, grant and RAM-port register computation.
  always_comb begin
    state_d     = state_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    starve_d    = starve_q;
    acc_rd_d    = acc_rd_q;
    ld_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!ld_valid) begin
          starve_d = '0;
        end
        if (ld_win_c) begin
          ld_ready    = 1'b1;
          ram_addr_d  = ld_addr;
          ram_wdata_d = ld_data;
          ram_we_d    = 1'b1;
          starve_d    = '0;
          state_d     = LOAD;
        end else if (cpu_req) begin
          ram_addr_d  = cpu_addr;
          ram_wdata_d = cpu_wdata;
          ram_we_d    = cpu_we & (cpu_addr >= ROM_TOP);
          acc_rd_d    = ~cpu_we;
          if (ld_valid && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          state_d = CPU_ACC;
        end
      end
      CPU_ACC: begin
        ram_we_d = 1'b0;
        state_d  = CPU_CAP;
      end
      CPU_CAP: begin
        if (acc_rd_q) begin
          cpu_rdata_d = ram_rdata;
        end
        cpu_ack_d = 1'b1;
        state_d   = CPU_ACK;
      end
      CPU_ACK: begin
        state_d = IDLE;
      end
      LOAD: begin
        ram_we_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        ram_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      starve_q    <= '0;
      acc_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      starve_q    <= starve_d;
      acc_rd_q    <= acc_rd_d;
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_wait_n = ~(cpu_req & ~cpu_ack_q);
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait_n;
  logic        ld_valid;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  mem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_wait_n(cpu_wait_n),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Scoreboards: expected CPU completions and expected RAM writes.
  typedef struct packed { logic is_rd; logic [7:0] rdata; } cpu_exp_t;
  cpu_exp_t    cpu_q[$];
  logic [23:0] wr_q[$];

  bit sat_phase = 0;
  int acks_since = 0;

  // Monitor: compare completions and RAM writes against queued expectations.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cpu_ack) begin
        if (sat_phase) acks_since++;
        if (cpu_q.size() == 0) chk("unexpected_ack", 32'(cpu_ack), 32'd0);
        else begin
          cpu_exp_t e;
          e = cpu_q.pop_front();
          if (e.is_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
        end
      end
      if (ram_we) begin
        if (sat_phase) begin
          chk("acks_before_loader", 32'(acks_since), 32'd4);
          acks_since = 0;
        end
        if (wr_q.size() == 0) chk("unexpected_ram_we", 32'(ram_addr), 32'hFFFF_FFFF);
        else chk("ram_write_addr_data", 32'({ram_addr, ram_wdata}), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input logic exp_wr, input bit chk_lat);
    cpu_exp_t e;
    int n;
    bit got;
    @(negedge clk);
    e.is_rd = ~we;
    e.rdata = exp_rd;
    cpu_q.push_back(e);
    if (exp_wr) wr_q.push_back({addr, wd});
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    if (chk_lat) begin
      #1;
      chk("wait_n_low_pending", 32'(cpu_wait_n), 32'd0);
    end
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (cpu_ack) got = 1;
    end
    if (!got) fail_now("cpu_ack_wait");
    else if (chk_lat) begin
      chk("ack_latency", 32'(n), 32'd3);
      chk("wait_n_high_at_ack", 32'(cpu_wait_n), 32'd1);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic ld_send(input logic [15:0] addr, input logic [7:0] d, input int budget,
                         output int acc_cyc);
    int n;
    bit got;
    wr_q.push_back({addr, d});
    ld_valid = 1'b1; ld_addr = addr; ld_data = d;
    n = 0; got = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (ld_ready) got = 1;
    end
    if (!got) begin
      fail_now("ld_ready_wait");
      acc_cyc = -1;
    end else acc_cyc = cyc;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ld_cyc[8];
    int n;
    bit got;
    cpu_exp_t e;

    vecs[0] = '{1'b0, 16'h4000, 8'h00, 8'h5A, 1'b0};
    vecs[1] = '{1'b1, 16'h4001, 8'hA5, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 16'h4001, 8'h00, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 16'h0000, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 8'h00, 8'hC3, 1'b0};
    vecs[5] = '{1'b1, 16'h3000, 8'h77, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 16'h3000, 8'h00, 8'h77, 1'b0};
    vecs[7] = '{1'b1, 16'h2FFF, 8'h11, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 16'h2FFF, 8'h00, 8'h9E, 1'b0};
    vecs[9] = '{1'b0, 16'hFFFF, 8'h00, 8'hEE, 1'b0};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hC3;
    mem[16'h2FFF] = 8'h9E;
    mem[16'h4000] = 8'h5A;
    mem[16'hFFFF] = 8'hEE;

    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    ld_valid = 1'b0; ld_addr = 16'h0; ld_data = 8'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_wait_n_req1", 32'(cpu_wait_n), 32'd0);
    cpu_req = 1'b0;
    #1;
    chk("rst_wait_n_req0", 32'(cpu_wait_n), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven CPU reads/writes, including the ROM window edges.
    for (int i = 0; i < 10; i++)
      cpu_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_wr, 1'b1);

    // Loader stream with the CPU idle: one byte every second cycle.
    for (int i = 0; i < 8; i++) ld_send(16'h5000 + 16'(i), 8'(i), 10, ld_cyc[i]);
    for (int i = 1; i < 8; i++) chk("ld_spacing", 32'(ld_cyc[i] - ld_cyc[i-1]), 32'd2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) chk("ld_mem_content", 32'(mem[16'h5000 + 16'(i)]), 32'(i));

    // Both requesters saturated: four CPU accesses per loader byte.
    repeat (2) @(negedge clk);
    sat_phase = 1;
    acks_since = 0;
    fork
      begin : sat_cpu
        for (int i = 0; i < 12; i++) cpu_access(1'b0, 16'h4000, 8'h00, 8'h5A, 1'b0, 1'b0);
      end
      begin : sat_ld
        int c;
        @(negedge clk);
        for (int j = 0; j < 3; j++) ld_send(16'h6000 + 16'(j), 8'h80 + 8'(j), 60, c);
      end
    join
    repeat (2) @(negedge clk);
    sat_phase = 0;
    for (int j = 0; j < 3; j++) chk("sat_mem_content", 32'(mem[16'h6000 + 16'(j)]), 32'(8'h80 + 8'(j)));

    // Simultaneous request from a cleared counter: CPU first, then loader.
    repeat (2) @(negedge clk);
    e.is_rd = 1'b1; e.rdata = 8'hA5;
    cpu_q.push_back(e);
    wr_q.push_back({16'h7000, 8'h3C});
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4001; cpu_wdata = 8'h00;
    ld_valid = 1'b1; ld_addr = 16'h7000; ld_data = 8'h3C;
    #1;
    chk("simul_ld_ready_low", 32'(ld_ready), 32'd0);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (cpu_ack) got = 1;
    end
    if (!got) fail_now("simul_cpu_ack");
    else chk("simul_cpu_latency", 32'(n), 32'd3);
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    chk("simul_ld_ready_next_idle", 32'(ld_ready), 32'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("simul_ld_mem", 32'(mem[16'h7000]), 32'h3C);

    // Reset pulsed during CPU_CAP: access abandoned, outputs back to reset.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("midrst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_ram_wdata", 32'(ram_wdata), 32'd0);
    cpu_req = 1'b0;
    got = 0;
    repeat (2) begin
      @(negedge clk);
      if (cpu_ack || ram_we) got = 1;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack || ram_we) got = 1;
    end
    chk("midrst_no_ack_or_we", 32'(got), 32'd0);
    cpu_access(1'b0, 16'h4001, 8'h00, 8'hA5, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
